// File: rtl/cam_pkg.sv
// cam_pkg: shared types and defaults for the camera frame capture block
package cam_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_BPP          = 1;
  localparam int DEF_ADDR_W       = 15;
  localparam int DEF_FRAME_PIXELS = 9216;
  localparam int DEF_XCLK_HALF    = 5;
  localparam int SYNC_DEPTH       = 2;
endpackage

// File: rtl/camera_frame_capture_if.sv
// camera_frame_capture_if: camera pin bundle plus frame RAM write port
//   master: capture side (samples plk/vs/hs/d, drives xlk and the RAM write port)
//   slave : sensor/RAM side
interface camera_frame_capture_if
  import cam_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int BYTES_PER_PIXEL = DEF_BPP,
  parameter int ADDR_W          = DEF_ADDR_W
);
  logic                              plk;
  logic                              vs;
  logic                              hs;
  logic [DATA_W-1:0]                 d;
  logic                              xlk;
  logic [ADDR_W-1:0]                 ram_address;
  logic [DATA_W*BYTES_PER_PIXEL-1:0] ram_data;
  logic                              ram_write_enable;
  modport master (input plk, vs, hs, d, output xlk, ram_address, ram_data, ram_write_enable);
  modport slave (output plk, vs, hs, d, input xlk, ram_address, ram_data, ram_write_enable);
endinterface

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: multi-flop synchroniser with rise/fall detection per bit
//   i_Clk, i_Rst_n : clock, async active-low reset
//   i_D            : asynchronous inputs
//   o_Q            : synchronised value
//   o_Rise/o_Fall  : one-cycle edge flags on the synchronised value
module cam_sync_edge
  import cam_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic [W-1:0] i_D,
  output logic [W-1:0] o_Q,
  output logic [W-1:0] o_Rise,
  output logic [W-1:0] o_Fall
);
  logic [W-1:0] r_sync [SYNC_DEPTH];
  logic [W-1:0] r_prev;
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      r_sync <= '{default: '0};
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_D;
      for (int i = 1; i < SYNC_DEPTH; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_DEPTH-1];
    end
  assign o_Q    = r_sync[SYNC_DEPTH-1];
  assign o_Rise = o_Q & ~r_prev;
  assign o_Fall = ~o_Q & r_prev;
endmodule

// File: rtl/camera_frame_capture.sv
// camera_frame_capture: samples a parallel camera bus and writes packed pixels of whole frames into RAM
//   i_Clk, i_Rst_n        : system clock, async active-low reset
//   cam (master)          : camera pins in, XCLK out, RAM write port out
//   i_Start/i_Continuous  : arm capture / re-arm after every frame
//   o_Busy, o_Frame_Done  : not idle / one-cycle frame-end pulse
//   o_Overflow            : sticky, words dropped past FRAME_PIXELS
//   o_Pixel_Count         : words written in the last completed frame
//   o_Frame_Count         : completed frames, wrapping
module camera_frame_capture
  import cam_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int BYTES_PER_PIXEL = DEF_BPP,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int FRAME_PIXELS    = DEF_FRAME_PIXELS,
  parameter int XCLK_HALF       = DEF_XCLK_HALF
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  camera_frame_capture_if.master cam,
  input  logic                   i_Start,
  input  logic                   i_Continuous,
  output logic                   o_Busy,
  output logic                   o_Frame_Done,
  output logic                   o_Overflow,
  output logic [ADDR_W:0]        o_Pixel_Count,
  output logic [7:0]             o_Frame_Count
);
  localparam int RAM_W = DATA_W * BYTES_PER_PIXEL;
  localparam int XW = XCLK_HALF > 1 ? $clog2(XCLK_HALF) : 1;
  localparam logic [ADDR_W:0] FP = (ADDR_W+1)'(FRAME_PIXELS);
  logic [XW-1:0]     r_xcnt;
  logic              r_xlk;
  state_t            r_state;
  logic              r_phase;
  logic [DATA_W-1:0] r_hi;
  logic [ADDR_W:0]   r_waddr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [RAM_W-1:0]  r_ram_data;
  logic              r_we;
  logic              r_done;
  logic              r_ovf;
  logic [ADDR_W:0]   r_pcnt;
  logic [7:0]        r_fcnt;
  logic [DATA_W+2:0] w_q, w_rise, w_fall;
  logic [2*DATA_W+3:0] w_unused;
  logic [DATA_W-1:0] w_d;
  logic w_hs, w_plk_rise, w_vs_rise, w_vs_fall, w_hs_fall;
  logic w_xwrap, w_pix, w_last, w_room, w_wr;
  logic [RAM_W-1:0]  w_word;
  // Control and data share one synchroniser so bytes stay aligned with their PLK edge
  cam_sync_edge #(.W(DATA_W+3)) u_sync (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_D    ({cam.hs, cam.vs, cam.plk, cam.d}),
    .o_Q    (w_q),
    .o_Rise (w_rise),
    .o_Fall (w_fall)
  );
  assign w_d        = w_q[DATA_W-1:0];
  assign w_hs       = w_q[DATA_W+2];
  assign w_plk_rise = w_rise[DATA_W];
  assign w_vs_rise  = w_rise[DATA_W+1];
  assign w_vs_fall  = w_fall[DATA_W+1];
  assign w_hs_fall  = w_fall[DATA_W+2];
  assign w_unused   = {w_rise[DATA_W-1:0], w_rise[DATA_W+2], w_fall[DATA_W:0], w_q[DATA_W+1:DATA_W]};
  assign w_xwrap = r_xcnt == XW'(XCLK_HALF-1);
  assign w_pix   = w_plk_rise & w_hs;
  assign w_last  = BYTES_PER_PIXEL == 1 || r_phase;
  assign w_room  = r_waddr < FP;
  assign w_wr    = w_pix & w_last & w_room;
  // First byte of a pixel lands in the MSBs; truncation leaves just the live byte when packing one
  assign w_word  = RAM_W'({r_hi, w_d});
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      r_xcnt <= '0;
      r_xlk  <= 1'b0;
    end else begin
      r_xcnt <= w_xwrap ? '0 : r_xcnt + 1'b1;
      r_xlk  <= w_xwrap ? ~r_xlk : r_xlk;
    end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      r_state    <= IDLE;
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_waddr    <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_pcnt     <= '0;
      r_fcnt     <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_Start) begin
          r_state <= WAIT_FRAME;
          r_ovf   <= 1'b0;
          r_phase <= 1'b0;
        end
        WAIT_FRAME: if (w_vs_fall) begin
          r_state <= CAPTURE;
          r_waddr <= '0;
          r_phase <= 1'b0;
        end
        CAPTURE: begin
          if (w_pix) begin
            r_phase <= ~w_last;
            r_hi    <= w_d;
            if (w_last && w_room) begin
              r_we       <= 1'b1;
              r_ram_addr <= r_waddr[ADDR_W-1:0];
              r_ram_data <= w_word;
              r_waddr    <= r_waddr + 1'b1;
            end
            if (w_last && !w_room) r_ovf <= 1'b1;
          end
          if (w_hs_fall) r_phase <= 1'b0;
          // A pixel completing in the same cycle as VS rise is counted in this frame
          if (w_vs_rise) begin
            r_done  <= 1'b1;
            r_pcnt  <= r_waddr + (ADDR_W+1)'(w_wr);
            r_fcnt  <= r_fcnt + 1'b1;
            r_phase <= 1'b0;
            r_state <= i_Continuous ? WAIT_FRAME : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  assign cam.xlk              = r_xlk;
  assign cam.ram_address      = r_ram_addr;
  assign cam.ram_data         = r_ram_data;
  assign cam.ram_write_enable = r_we;
  assign o_Busy        = r_state != IDLE;
  assign o_Frame_Done  = r_done;
  assign o_Overflow    = r_ovf;
  assign o_Pixel_Count = r_pcnt;
  assign o_Frame_Count = r_fcnt;
endmodule

// File: tb/tb_camera_frame_capture.sv
// tb_camera_frame_capture: directed frame sequences with random pixel data against a byte-pairing model
module tb_camera_frame_capture;
  localparam int DW = 8, BPP = 2, AW = 4, FP = 8, XH = 5;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0;
  logic busy, done, ovf;
  logic [AW:0] pcnt;
  logic [7:0] fcnt;
  int n_cmp = 0, n_fail = 0, done_cnt = 0, d0 = 0, fc = 0;
  int wa[$], wd[$], exp_words[$], line_len[$];
  camera_frame_capture_if #(.DATA_W(DW), .BYTES_PER_PIXEL(BPP), .ADDR_W(AW)) cam ();
  camera_frame_capture #(
    .DATA_W(DW), .BYTES_PER_PIXEL(BPP), .ADDR_W(AW), .FRAME_PIXELS(FP), .XCLK_HALF(XH)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .cam(cam), .i_Start(start), .i_Continuous(cont),
    .o_Busy(busy), .o_Frame_Done(done), .o_Overflow(ovf),
    .o_Pixel_Count(pcnt), .o_Frame_Count(fcnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (cam.ram_write_enable === 1'b1) begin
      wa.push_back(int'(cam.ram_address));
      wd.push_back(int'(cam.ram_data));
    end
    if (done === 1'b1) done_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pix(input logic h, input logic [7:0] v);
    cam.plk = 1'b0;
    cam.hs  = h;
    cam.d   = v;
    repeat (4) @(negedge clk);
    cam.plk = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic send_frame(input bit seq);
    int b = 0;
    logic [7:0] byt, hi;
    hi = 8'h00;
    exp_words.delete();
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    cam.vs = 1'b1;
    repeat (3) pix(1'b0, 8'h00);
    cam.vs = 1'b0;
    repeat (2) pix(1'b0, 8'h00);
    foreach (line_len[l]) begin
      for (int j = 0; j < line_len[l]; j++) begin
        byt = seq ? 8'(b + 1) : 8'($urandom);
        b++;
        if (j % 2 == 1) exp_words.push_back(int'({hi, byt}));
        else hi = byt;
        pix(1'b1, byt);
      end
      repeat (2) pix(1'b0, 8'h00);
    end
    cam.vs = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  task automatic check_frame(input string tag, input logic exp_busy);
    int n = exp_words.size() < FP ? exp_words.size() : FP;
    fc = (fc + 1) % 256;
    chk({tag, " writes"}, wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk({tag, " addr"}, wa[i], i);
      chk({tag, " data"}, wd[i], exp_words[i]);
    end
    chk({tag, " done pulses"}, done_cnt - d0, 1);
    chk({tag, " pixel count"}, pcnt, n);
    chk({tag, " overflow"}, ovf, exp_words.size() > FP);
    chk({tag, " frame count"}, fcnt, fc);
    chk({tag, " busy"}, busy, exp_busy);
  endtask
  initial begin
    int r1 = -1, r2 = -1;
    logic prev;
    cam.plk = 1'b0;
    cam.vs  = 1'b0;
    cam.hs  = 1'b0;
    cam.d   = '0;
    repeat (3) @(negedge clk);
    chk("rst xlk", cam.xlk, 0);
    chk("rst ram addr", cam.ram_address, 0);
    chk("rst ram data", cam.ram_data, 0);
    chk("rst we", cam.ram_write_enable, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst overflow", ovf, 0);
    chk("rst pixel count", pcnt, 0);
    chk("rst frame count", fcnt, 0);
    rst_n = 1'b1;
    prev = cam.xlk;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!prev && cam.xlk) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = cam.xlk;
    end
    chk("xlk first rise", r1, 5);
    chk("xlk period", r2 - r1, 2 * XH);
    pulse_start();
    chk("busy after start", busy, 1);
    line_len = '{8, 8};
    send_frame(1'b1);
    chk("first word", wd.size() > 0 ? wd[0] : -1, 32'h0102);
    check_frame("seq", 1'b0);
    pulse_start();
    line_len = '{3, 5};
    send_frame(1'b0);
    check_frame("odd", 1'b0);
    pulse_start();
    line_len = '{10, 10};
    send_frame(1'b0);
    check_frame("ovf", 1'b0);
    cont = 1'b1;
    pulse_start();
    line_len = '{4, 4};
    send_frame(1'b0);
    check_frame("cont1", 1'b1);
    line_len = '{$urandom_range(1, 8), $urandom_range(1, 8)};
    send_frame(1'b0);
    check_frame("cont2", 1'b1);
    cont = 1'b0;
    line_len = '{2, 6};
    send_frame(1'b0);
    check_frame("cont3", 1'b0);
    pulse_start();
    cam.vs = 1'b1;
    repeat (3) pix(1'b0, 8'h00);
    cam.vs = 1'b0;
    pix(1'b0, 8'h00);
    pix(1'b1, 8'hAA);
    pix(1'b1, 8'hBB);
    pix(1'b1, 8'hCC);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst we", cam.ram_write_enable, 0);
    chk("async rst ram addr", cam.ram_address, 0);
    chk("async rst ram data", cam.ram_data, 0);
    chk("async rst frame count", fcnt, 0);
    chk("async rst pixel count", pcnt, 0);
    chk("async rst xlk", cam.xlk, 0);
    fc = 0;
    @(negedge clk) rst_n = 1'b1;
    line_len = '{4, 4};
    send_frame(1'b0);
    chk("no start writes", wa.size(), 0);
    chk("no start done", done_cnt - d0, 0);
    chk("no start busy", busy, 0);
    pulse_start();
    send_frame(1'b0);
    check_frame("post rst", 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
